// File: rtl/demux_pipe_pkg.sv
// Shared types and defaults for the demux pipe.
package demux_pipe_pkg;

  localparam int unsigned DEF_DATA_W     = 128;
  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned DEF_DEST_LSB   = 96;
  localparam int unsigned DEST_W         = 32;

  typedef logic [DEST_W-1:0] dest_t;

  localparam dest_t DEF_FWD_ID = 32'd1;

  // Elaboration-time ceil(log2(v)), minimum 1 so a pointer is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags, registered head and occupancy count.
module demux_fifo
  import demux_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head,
  output logic                      full,
  output logic                      empty,
  output logic [clog2(FIFO_DEPTH):0] count
);

  localparam int unsigned PtrW = clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_q, wr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_q];
  // A full FIFO refuses a push even if it is popped in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (do_pop) rd_q <= rd_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/demux_pipe.sv
// Steers one enq stream to out/forward by destination field via two FIFOs.
// DEMUX_PIPE_BYPASS_EN: empty FIFO with a ready sink passes the word through in the same cycle.
module demux_pipe
  import demux_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned DEST_LSB   = DEF_DEST_LSB,
  parameter dest_t       FWD_ID     = DEF_FWD_ID
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_enq_ena_i,
  input  logic [DATA_W-1:0] in_enq_v_i,
  output logic              in_enq_rdy_o,
  output logic              out_enq_ena_o,
  output logic [DATA_W-1:0] out_enq_v_o,
  input  logic              out_enq_rdy_i,
  output logic              forward_enq_ena_o,
  output logic [DATA_W-1:0] forward_enq_v_o,
  input  logic              forward_enq_rdy_i
);

  localparam int unsigned CntW = clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] head_o, head_f;
  logic              full_o, full_f, empty_o, empty_f;
  logic [CntW-1:0]   cnt_o, cnt_f;
  logic              is_fwd, accept, byp_o, byp_f, push_o, push_f, pop_o, pop_f;
  dest_t             dest;

  assign dest         = in_enq_v_i[DEST_LSB +: DEST_W];
  assign is_fwd       = (dest == FWD_ID);
  assign in_enq_rdy_o = ~full_o & ~full_f;
  // Words strobed while not ready are dropped; reset overrides everything.
  assign accept       = in_enq_ena_i & in_enq_rdy_o & ~RST;

`ifdef DEMUX_PIPE_BYPASS_EN
  assign byp_o = accept & ~is_fwd & empty_o & out_enq_rdy_i;
  assign byp_f = accept & is_fwd & empty_f & forward_enq_rdy_i;
`else
  assign byp_o = 1'b0;
  assign byp_f = 1'b0;
`endif

  assign push_o = accept & ~is_fwd & ~byp_o;
  assign push_f = accept & is_fwd & ~byp_f;
  assign pop_o  = ~empty_o & out_enq_rdy_i & ~RST;
  assign pop_f  = ~empty_f & forward_enq_rdy_i & ~RST;

  assign out_enq_ena_o     = pop_o | byp_o;
  assign forward_enq_ena_o = pop_f | byp_f;
  assign out_enq_v_o       = byp_o ? in_enq_v_i : head_o;
  assign forward_enq_v_o   = byp_f ? in_enq_v_i : head_f;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (cnt_o <= CntW'(FIFO_DEPTH) && cnt_f <= CntW'(FIFO_DEPTH))
        else $error("fifo count out of range");
    end
  end

  demux_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_o (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_o),
    .data  (in_enq_v_i),
    .pop   (pop_o),
    .head  (head_o),
    .full  (full_o),
    .empty (empty_o),
    .count (cnt_o)
  );

  demux_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_f (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_f),
    .data  (in_enq_v_i),
    .pop   (pop_f),
    .head  (head_f),
    .full  (full_f),
    .empty (empty_f),
    .count (cnt_f)
  );

endmodule
